// File: rtl/fpu_addsub_ctrl.sv
// Single-request sequencer for the FP32 add/sub path: exception check first, then special result or datapath launch.
// Optional datapath watchdog is compiled in with the macro FPU_TIMEOUT_EN.
module fpu_addsub_ctrl #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_op,
   output logic [WIDTH-1:0] exc_a,
   output logic [WIDTH-1:0] exc_b,
   output logic             exc_op,
   input  logic [2:0]       exc_flag,
   input  logic [WIDTH-2:0] exc_operand,
   output logic             dp_start,
   input  logic             dp_done,
   input  logic [WIDTH-1:0] dp_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_exc,
   output logic             rsp_err
);
   localparam logic [WIDTH-1:0] QNAN     = 32'h7FC0_0000;
   localparam logic [WIDTH-2:0] INF_MAG  = 31'h7F80_0000;
   localparam logic [WIDTH-2:0] ZERO_MAG = {(WIDTH-1){1'b0}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      CHECK = 3'd2,
      EXEC  = 3'd3,
      RESP  = 3'd4
   } state_t;

   // Special-case result for a non-zero exception flag; sb is the effective sign of b.
   function automatic logic [WIDTH-1:0] exc_result(
      input logic [2:0]       flag,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             op,
      input logic [WIDTH-2:0] mag
   );
      logic             sb;
      logic [WIDTH-1:0] res;
      sb  = b[WIDTH-1] ^ op;
      res = QNAN;
      case (flag)
         3'b001: res = QNAN;
         3'b010: res = {a[WIDTH-1], mag};
         3'b011: res = {sb, mag};
         3'b100: begin
            if ((mag == INF_MAG) && (a[WIDTH-2:0] == INF_MAG) && (a[WIDTH-1] != sb)) begin
               res = QNAN;
            end else begin
               res = {sb, mag};
            end
         end
         3'b101: res = {a[WIDTH-1] & sb, ZERO_MAG};
         3'b110: begin
            if (a[WIDTH-2:0] != ZERO_MAG) begin
               res = {a[WIDTH-1], mag};
            end else begin
               res = {sb, mag};
            end
         end
         3'b111: res = {1'b0, ZERO_MAG};
         default: res = QNAN;
      endcase
      return res;
   endfunction

   state_t           state_r, state_next_s;
   logic [WIDTH-1:0] exc_a_r, exc_a_next_s;
   logic [WIDTH-1:0] exc_b_r, exc_b_next_s;
   logic             exc_op_r, exc_op_next_s;
   logic             dp_start_r, dp_start_next_s;
   logic             req_ready_r, req_ready_next_s;
   logic             rsp_valid_r, rsp_valid_next_s;
   logic [WIDTH-1:0] rsp_result_r, rsp_result_next_s;
   logic             rsp_exc_r, rsp_exc_next_s;
   logic             rsp_err_r, rsp_err_next_s;

`ifdef FPU_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_next_s;
`endif

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_next_s      = state_r;
      exc_a_next_s      = exc_a_r;
      exc_b_next_s      = exc_b_r;
      exc_op_next_s     = exc_op_r;
      dp_start_next_s   = 1'b0;
      rsp_valid_next_s  = rsp_valid_r;
      rsp_result_next_s = rsp_result_r;
      rsp_exc_next_s    = rsp_exc_r;
      rsp_err_next_s    = rsp_err_r;
`ifdef FPU_TIMEOUT_EN
      tmo_cnt_next_s    = tmo_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               exc_a_next_s   = req_a;
               exc_b_next_s   = req_b;
               exc_op_next_s  = req_op;
               rsp_err_next_s = 1'b0;
               state_next_s   = ISSUE;
            end else begin
               state_next_s   = IDLE;
            end
         end
         ISSUE: state_next_s = CHECK;
         CHECK: begin
            if (exc_flag == 3'b000) begin
               dp_start_next_s = 1'b1;
               state_next_s    = EXEC;
`ifdef FPU_TIMEOUT_EN
               tmo_cnt_next_s  = {TMO_W{1'b0}};
`endif
            end else begin
               rsp_result_next_s = exc_result(exc_flag, exc_a_r, exc_b_r, exc_op_r, exc_operand);
               rsp_exc_next_s    = 1'b1;
               rsp_valid_next_s  = 1'b1;
               state_next_s      = RESP;
            end
         end
         EXEC: begin
            // A dp_done coinciding with the last watchdog cycle still delivers the real result.
            if (dp_done) begin
               rsp_result_next_s = dp_result;
               rsp_exc_next_s    = 1'b0;
               rsp_err_next_s    = 1'b0;
               rsp_valid_next_s  = 1'b1;
               state_next_s      = RESP;
            end
`ifdef FPU_TIMEOUT_EN
            else if (tmo_cnt_r == TMO_LAST) begin
               rsp_result_next_s = QNAN;
               rsp_exc_next_s    = 1'b0;
               rsp_err_next_s    = 1'b1;
               rsp_valid_next_s  = 1'b1;
               state_next_s      = RESP;
            end else begin
               tmo_cnt_next_s    = tmo_cnt_r + TMO_W'(1);
            end
`else
            else begin
               state_next_s = EXEC;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_next_s = 1'b0;
               state_next_s     = IDLE;
            end else begin
               state_next_s     = RESP;
            end
         end
         default: begin
            rsp_valid_next_s = 1'b0;
            state_next_s     = IDLE;
         end
      endcase
      req_ready_next_s = (state_next_s == IDLE);
   end

   // State and registered outputs; reset drops any in-flight operation.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_r      <= IDLE;
         exc_a_r      <= {WIDTH{1'b0}};
         exc_b_r      <= {WIDTH{1'b0}};
         exc_op_r     <= 1'b0;
         dp_start_r   <= 1'b0;
         req_ready_r  <= 1'b1;
         rsp_valid_r  <= 1'b0;
         rsp_result_r <= {WIDTH{1'b0}};
         rsp_exc_r    <= 1'b0;
         rsp_err_r    <= 1'b0;
`ifdef FPU_TIMEOUT_EN
         tmo_cnt_r    <= {TMO_W{1'b0}};
`endif
      end else begin
         state_r      <= state_next_s;
         exc_a_r      <= exc_a_next_s;
         exc_b_r      <= exc_b_next_s;
         exc_op_r     <= exc_op_next_s;
         dp_start_r   <= dp_start_next_s;
         req_ready_r  <= req_ready_next_s;
         rsp_valid_r  <= rsp_valid_next_s;
         rsp_result_r <= rsp_result_next_s;
         rsp_exc_r    <= rsp_exc_next_s;
         rsp_err_r    <= rsp_err_next_s;
`ifdef FPU_TIMEOUT_EN
         tmo_cnt_r    <= tmo_cnt_next_s;
`endif
      end
   end

   assign req_ready  = req_ready_r;
   assign exc_a      = exc_a_r;
   assign exc_b      = exc_b_r;
   assign exc_op     = exc_op_r;
   assign dp_start   = dp_start_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_result = rsp_result_r;
   assign rsp_exc    = rsp_exc_r;
   assign rsp_err    = rsp_err_r;

endmodule
